regfile_stream_loader: RTL

//  Upstream fill engine for the multi-ported register file. Accepts a byte stream
//  (valid/ready), packs bytes little-endian into data_width words, and drives the

---
 rtl/regfile_stream_loader_pkg.sv | 17 +
 rtl/regfile_stream_loader_stream_word_packer.sv | 51 +++++
 rtl/regfile_stream_loader.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/regfile_stream_loader_pkg.sv
// Shared types and helpers for the register file stream loader.
package regfile_stream_loader_pkg;

   // Loader control states, 2-bit encoding.
   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StCollect = 2'd1,
      StWrite   = 2'd2,
      StDone    = 2'd3
   } state_t;

   // Number of stream bytes that make up one register file word.
   function automatic int unsigned bytes_per_word(input int unsigned width);
      return width / 8;
   endfunction

endpackage

// File: rtl/regfile_stream_loader_stream_word_packer.sv
// Byte-to-word packer: inserts stream bytes little-endian into a word and tracks
// the byte index within the word.
module stream_word_packer
   import regfile_stream_loader_pkg::*;
#(
   parameter int unsigned data_width = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  load,
   input  logic [7:0]            byte_in,
   output logic [data_width-1:0] word,
   output logic                  last_byte
);

   localparam int unsigned NB = bytes_per_word(data_width);
   localparam int unsigned IW = (NB > 1) ? $clog2(NB) : 1;

   logic [IW-1:0]         idx_q, idx_d;
   logic [data_width-1:0] word_q, word_d;

   assign last_byte = (idx_q == IW'(NB - 1));
   // Word as it stands after the byte being accepted this cycle, so the top can
   // capture a complete word on the same edge as the final byte.
   assign word = word_d;

   // Next index and byte insertion.
   always_comb begin
      idx_d  = idx_q;
      word_d = word_q;
      if (clear) begin
         idx_d = '0;
      end else if (load) begin
         word_d[8*idx_q +: 8] = byte_in;
         idx_d = last_byte ? '0 : idx_q + 1'b1;
      end
   end

   // Index and partial word registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q  <= '0;
         word_q <= '0;
      end else begin
         idx_q  <= idx_d;
         word_q <= word_d;
      end
   end

endmodule

// File: rtl/regfile_stream_loader.sv
// Stream loader: packs a byte stream into words and writes them to the register
// file from lo to hi, one WE pulse per word.
module regfile_stream_loader
   import regfile_stream_loader_pkg::*;
#(
   parameter int unsigned addr_width = 8,
   parameter int unsigned data_width = 32,
   parameter int unsigned lo         = 0,
   parameter int unsigned hi         = 255
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  START,
   input  logic                  ABORT,
   input  logic                  BYTE_VALID,
   input  logic [7:0]            BYTE_DATA,
   output logic                  BYTE_READY,
   output logic [addr_width-1:0] ADDR_IN,
   output logic [data_width-1:0] D_IN,
   output logic                  WE,
   output logic                  BUSY,
   output logic                  DONE,
   output logic [addr_width:0]   COUNT,
   output logic [7:0]            CHECKSUM
);

   if ((data_width % 8 != 0) || (data_width < 8) || (hi < lo)) begin : g_bad_params
      $error("regfile_stream_loader: illegal data_width/lo/hi parameters");
   end

   localparam logic [addr_width-1:0] LoA = addr_width'(lo);
   localparam logic [addr_width-1:0] HiA = addr_width'(hi);

   state_t                state_q, state_d;
   logic [addr_width-1:0] addr_q, addr_d;
   logic [addr_width:0]   count_q, count_d;
   logic [7:0]            checksum_q, checksum_d;
   logic                  we_q, we_d;
   logic [addr_width-1:0] addr_out_q, addr_out_d;
   logic [data_width-1:0] d_out_q, d_out_d;

   logic                  xfer;
   logic                  abort_ok;
   logic                  start_ok;
   logic                  pack_clear;
   logic [data_width-1:0] pack_word;
   logic                  pack_last;

   assign xfer       = BYTE_VALID && (state_q == StCollect);
   assign abort_ok   = ABORT && (state_q != StIdle);
   assign start_ok   = START && ((state_q == StIdle) || (state_q == StDone));
   assign pack_clear = abort_ok || start_ok;

   stream_word_packer #(
      .data_width(data_width)
   ) u_packer (
      .clk      (CLK),
      .rst_n    (RST_N),
      .clear    (pack_clear),
      .load     (xfer),
      .byte_in  (BYTE_DATA),
      .word     (pack_word),
      .last_byte(pack_last)
   );

   // Next-state, address, counters and write-port capture.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      count_d    = count_q;
      checksum_d = checksum_q;
      we_d       = 1'b0;
      addr_out_d = addr_out_q;
      d_out_d    = d_out_q;
      if (abort_ok) begin
         state_d = StIdle;
      end else begin
         case (state_q)
            StIdle, StDone: begin
               if (START) begin
                  state_d    = StCollect;
                  addr_d     = LoA;
                  count_d    = '0;
                  checksum_d = '0;
               end
            end
            StCollect: begin
               if (xfer) begin
                  checksum_d = checksum_q + BYTE_DATA;
                  if (pack_last) begin
                     state_d    = StWrite;
                     we_d       = 1'b1;
                     addr_out_d = addr_q;
                     d_out_d    = pack_word;
                  end
               end
            end
            StWrite: begin
               count_d = count_q + 1'b1;
               if (addr_q == HiA) begin
                  state_d = StDone;
               end else begin
                  addr_d  = addr_q + 1'b1;
                  state_d = StCollect;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= StIdle;
         addr_q     <= '0;
         count_q    <= '0;
         checksum_q <= '0;
         we_q       <= 1'b0;
         addr_out_q <= '0;
         d_out_q    <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         count_q    <= count_d;
         checksum_q <= checksum_d;
         we_q       <= we_d;
         addr_out_q <= addr_out_d;
         d_out_q    <= d_out_d;
      end
   end

   assign BYTE_READY = (state_q == StCollect);
   assign BUSY       = (state_q == StCollect) || (state_q == StWrite);
   assign DONE       = (state_q == StDone);
   // ABORT in the write cycle must suppress the pending write.
   assign WE         = we_q && !ABORT;
   assign ADDR_IN    = addr_out_q;
   assign D_IN       = d_out_q;
   assign COUNT      = count_q;
   assign CHECKSUM   = checksum_q;

endmodule
